rf_write_arbiter: RTL and testbench

Shares the single register-file write port between the in-order writeback stage and the multi-cycle load-return path. Tracks in-flight load destinations in an 8-entry scoreboard so issue logic can stall on RAW/WAW hazards. Bounds load-return starvation with a wait counter that forces a pipeline stall. Sits between the writeback stage, the load unit and the register file.

---
 rtl/rf_write_arbiter.sv | 138 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter between writeback and load return, with an
// 8-entry in-flight load scoreboard and a starvation bound for load returns.
module rf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        wb_hb,
  input  logic        wb_lb,
  input  logic [2:0]  wb_regDest,
  input  logic [15:0] wb_dataIn,
  output logic        wb_stall,
  input  logic        ld_valid,
  input  logic        ld_hb,
  input  logic        ld_lb,
  input  logic [2:0]  ld_regDest,
  input  logic [15:0] ld_data,
  output logic        ld_ready,
  input  logic        ld_issue,
  input  logic [2:0]  ld_issueDest,
  input  logic [2:0]  chk_reg,
  output logic        chk_busy,
  output logic        sb_err,
  output logic [2:0]  rf_regDest,
  output logic [15:0] rf_dataIn,
  output logic        rf_we,
  output logic        rf_hb,
  output logic        rf_lb
);

  // Handshakes: a load return transfers on a cycle where ld_valid & ld_ready.
  // A writeback request (wb_hb | wb_lb) transfers on any cycle where en=1 and
  // wb_stall=0; otherwise upstream holds wb_* unchanged.

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic [7:0] pending_q, pending_d;
  logic       sb_err_q, sb_err_d;

  logic       wb_req;
  logic       grant_wb;
  logic       grant_ld;
  logic       ld_hs;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic       err_dup_issue;
  logic       err_bad_return;

  assign wb_req = wb_hb | wb_lb;

  always_comb begin
    grant_wb = 1'b0;
    grant_ld = 1'b0;
    if (rst_n && en) begin
      if (ld_valid && !wb_req) begin
        grant_ld = 1'b1;
      end else if (wb_req && !ld_valid) begin
        grant_wb = 1'b1;
      end else if (wb_req && ld_valid) begin
        // Same destination: the load is older, so it must land first.
        if (ld_regDest == wb_regDest) begin
          grant_ld = 1'b1;
        end else if (starve_q >= LIMIT) begin
          grant_ld = 1'b1;
        end else begin
          grant_wb = 1'b1;
        end
      end
    end
  end

  assign ld_ready = grant_ld;
  assign wb_stall = grant_ld & wb_req;
  assign ld_hs    = ld_valid & ld_ready;

  always_comb begin
    rf_regDest = 3'd0;
    rf_dataIn  = 16'd0;
    rf_hb      = 1'b0;
    rf_lb      = 1'b0;
    if (grant_ld) begin
      rf_regDest = ld_regDest;
      rf_dataIn  = ld_data;
      rf_hb      = ld_hb;
      rf_lb      = ld_lb;
    end else if (grant_wb) begin
      rf_regDest = wb_regDest;
      rf_dataIn  = wb_dataIn;
      rf_hb      = wb_hb;
      rf_lb      = wb_lb;
    end
  end

  assign rf_we = rf_hb | rf_lb;

  always_comb begin
    starve_d = starve_q;
    if (en) begin
      if (ld_valid && !ld_ready) begin
        if (starve_q != 4'hF) starve_d = starve_q + 4'd1;
      end else begin
        starve_d = 4'd0;
      end
    end
  end

  always_comb begin
    set_vec = 8'd0;
    clr_vec = 8'd0;
    if (en && ld_issue) set_vec[ld_issueDest] = 1'b1;
    if (ld_hs)          clr_vec[ld_regDest]   = 1'b1;
  end

  // Set is applied after clear so a same-cycle issue to a returning register wins.
  assign pending_d = (pending_q & ~clr_vec) | set_vec;

  assign err_dup_issue  = en & ld_issue & pending_q[ld_issueDest] & ~clr_vec[ld_issueDest];
  assign err_bad_return = ld_hs & ~pending_q[ld_regDest];
  assign sb_err_d       = sb_err_q | err_dup_issue | err_bad_return;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= 4'd0;
      pending_q <= 8'd0;
      sb_err_q  <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign chk_busy = pending_q[chk_reg];
  assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: arbitration, starvation bound,
// scoreboard set/clear, sticky error and asynchronous reset behaviour.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        wb_hb, wb_lb;
  logic [2:0]  wb_regDest;
  logic [15:0] wb_dataIn;
  logic        wb_stall;
  logic        ld_valid, ld_hb, ld_lb;
  logic [2:0]  ld_regDest;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        ld_issue;
  logic [2:0]  ld_issueDest;
  logic [2:0]  chk_reg;
  logic        chk_busy;
  logic        sb_err;
  logic [2:0]  rf_regDest;
  logic [15:0] rf_dataIn;
  logic        rf_we, rf_hb, rf_lb;

  int total = 0;
  int bad   = 0;

  rf_write_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .wb_hb(wb_hb), .wb_lb(wb_lb), .wb_regDest(wb_regDest), .wb_dataIn(wb_dataIn),
    .wb_stall(wb_stall),
    .ld_valid(ld_valid), .ld_hb(ld_hb), .ld_lb(ld_lb), .ld_regDest(ld_regDest),
    .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_issue(ld_issue), .ld_issueDest(ld_issueDest),
    .chk_reg(chk_reg), .chk_busy(chk_busy), .sb_err(sb_err),
    .rf_regDest(rf_regDest), .rf_dataIn(rf_dataIn),
    .rf_we(rf_we), .rf_hb(rf_hb), .rf_lb(rf_lb)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; combinational outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    wb_hb = 0; wb_lb = 0; wb_regDest = 0; wb_dataIn = 0;
    ld_valid = 0; ld_hb = 0; ld_lb = 0; ld_regDest = 0; ld_data = 0;
    ld_issue = 0; ld_issueDest = 0;
  endtask

  task automatic drive_wb(input logic hb, input logic lb, input logic [2:0] dst, input logic [15:0] d);
    wb_hb = hb; wb_lb = lb; wb_regDest = dst; wb_dataIn = d;
  endtask

  task automatic drive_ld(input logic v, input logic [2:0] dst, input logic [15:0] d);
    ld_valid = v; ld_hb = v; ld_lb = v; ld_regDest = dst; ld_data = d;
  endtask

  task automatic issue(input logic [2:0] dst);
    next_cycle();
    idle_inputs();
    ld_issue = 1; ld_issueDest = dst;
    next_cycle();
    ld_issue = 0;
  endtask

  initial begin
    en = 1; chk_reg = 0;
    idle_inputs();
    rst_n = 0;
    // writeback request during reset must not reach the register file
    drive_wb(0, 1, 3'd5, 16'h00AB);
    #2;
    check("rst_we", rf_we, 0);
    check("rst_dest", rf_regDest, 0);
    check("rst_data", rf_dataIn, 0);
    check("rst_stall", wb_stall, 0);
    check("rst_err", sb_err, 0);
    next_cycle();
    rst_n = 1;
    idle_inputs();
    settle();
    check("idle_we", rf_we, 0);
    check("idle_ldrdy", ld_ready, 0);
    check("idle_busy", chk_busy, 0);

    // plain writeback, low byte
    next_cycle();
    drive_wb(0, 1, 3'd5, 16'h00AB);
    settle();
    check("wb_we", rf_we, 1);
    check("wb_lb", rf_lb, 1);
    check("wb_hb", rf_hb, 0);
    check("wb_dest", rf_regDest, 5);
    check("wb_data", rf_dataIn, 16'h00AB);
    check("wb_stall", wb_stall, 0);

    // issue to reg 2: invisible this cycle, busy next
    next_cycle();
    idle_inputs();
    ld_issue = 1; ld_issueDest = 3'd2; chk_reg = 3'd2;
    settle();
    check("busy_same_cyc", chk_busy, 0);
    next_cycle();
    ld_issue = 0;
    settle();
    check("busy_r2", chk_busy, 1);
    drive_ld(1, 3'd2, 16'h1234);
    settle();
    check("ld_ready", ld_ready, 1);
    check("ld_we", rf_we, 1);
    check("ld_dest", rf_regDest, 2);
    check("ld_data", rf_dataIn, 16'h1234);
    next_cycle();
    idle_inputs();
    settle();
    check("busy_clr_r2", chk_busy, 0);
    check("err_clean1", sb_err, 0);

    // starvation: wb to reg 1 continuously, load to reg 3 waiting
    issue(3'd3);
    drive_wb(1, 0, 3'd1, 16'h1111);
    drive_ld(1, 3'd3, 16'h3333);
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("starve_c%0d_dest", c), rf_regDest, 1);
      check($sformatf("starve_c%0d_rdy", c), ld_ready, 0);
      check($sformatf("starve_c%0d_stall", c), wb_stall, 0);
      next_cycle();
    end
    settle();
    check("starve_c3_rdy", ld_ready, 1);
    check("starve_c3_stall", wb_stall, 1);
    check("starve_c3_dest", rf_regDest, 3);
    check("starve_c3_data", rf_dataIn, 16'h3333);
    next_cycle();
    drive_ld(0, 3'd0, 16'h0);
    settle();
    check("starve_c4_dest", rf_regDest, 1);
    check("starve_c4_stall", wb_stall, 0);
    check("starve_c4_data", rf_dataIn, 16'h1111);

    // same destination conflict at starve_cnt=0
    issue(3'd4);
    drive_wb(1, 1, 3'd4, 16'hAAAA);
    drive_ld(1, 3'd4, 16'h4444);
    settle();
    check("same_rdy", ld_ready, 1);
    check("same_stall", wb_stall, 1);
    check("same_data", rf_dataIn, 16'h4444);
    next_cycle();
    drive_ld(0, 3'd0, 16'h0);
    settle();
    check("same_wb_stall", wb_stall, 0);
    check("same_wb_data", rf_dataIn, 16'hAAAA);
    check("same_wb_we", rf_we, 1);

    // en=0 blocks everything and holds state
    next_cycle();
    en = 0;
    drive_wb(1, 0, 3'd1, 16'h5555);
    drive_ld(1, 3'd0, 16'h6666);
    ld_issue = 1; ld_issueDest = 3'd0;
    settle();
    check("dis_we", rf_we, 0);
    check("dis_stall", wb_stall, 0);
    check("dis_rdy", ld_ready, 0);
    next_cycle();
    en = 1;
    idle_inputs();
    chk_reg = 3'd0;
    settle();
    check("dis_no_issue", chk_busy, 0);
    check("dis_no_err", sb_err, 0);

    // simultaneous set and clear on reg 7
    issue(3'd7);
    drive_ld(1, 3'd7, 16'h7777);
    ld_issue = 1; ld_issueDest = 3'd7;
    settle();
    check("sc_rdy", ld_ready, 1);
    next_cycle();
    idle_inputs();
    chk_reg = 3'd7;
    settle();
    check("sc_busy", chk_busy, 1);
    check("sc_err", sb_err, 0);
    drive_ld(1, 3'd7, 16'h7777);
    next_cycle();
    idle_inputs();
    settle();
    check("sc_busy_clr", chk_busy, 0);
    check("sc_err2", sb_err, 0);

    // duplicate issue to reg 6
    ld_issue = 1; ld_issueDest = 3'd6;
    next_cycle();
    settle();
    check("dup_err_first", sb_err, 0);
    next_cycle();
    ld_issue = 0;
    settle();
    check("dup_err_set", sb_err, 1);
    next_cycle();
    next_cycle();
    settle();
    check("dup_err_hold", sb_err, 1);

    // only reset clears the sticky error
    rst_n = 0;
    #1;
    check("err_rst", sb_err, 0);
    next_cycle();
    rst_n = 1;
    drive_ld(1, 3'd0, 16'h0BAD);
    settle();
    check("bad_ret_rdy", ld_ready, 1);
    next_cycle();
    idle_inputs();
    settle();
    check("bad_ret_err", sb_err, 1);

    // async reset in the middle of a write burst
    rst_n = 0;
    next_cycle();
    rst_n = 1;
    issue(3'd5);
    drive_wb(1, 1, 3'd2, 16'hBEEF);
    settle();
    check("burst_we", rf_we, 1);
    chk_reg = 3'd5;
    settle();
    check("burst_busy", chk_busy, 1);
    #2;
    rst_n = 0;
    #1;
    check("async_we", rf_we, 0);
    check("async_busy", chk_busy, 0);
    check("async_data", rf_dataIn, 0);
    next_cycle();
    rst_n = 1;
    idle_inputs();
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
